stack_unit: RTL and testbench

- Hardware return/data stack in the MEM stage, directly downstream of the control unit.
- Consumes the control unit's stack controls (sigNewSP, sigStackMem, sigAddData, enMem) to execute PUSH/POP/CALL/RET.
- Returns fullFlag/emptyFlag to the control unit, and supplies the popped word to the PC mux (pcStack path, RET) and the write-back path (POP).

---
 rtl/stack_unit_pkg.sv | 15 +
 rtl/stack_ram.sv | 32 +++
 rtl/stack_unit.sv | 131 +++++++++++++
 tb/tb_stack_unit.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_unit_pkg.sv
// Shared constants for the MEM-stage hardware stack.
//   - Stack-op encodings driven by the control unit on sigNewSP.
//   - Qualifier FSM state encodings used inside stack_unit.
package stack_unit_pkg;

  // Stack-op codes (2'b11 is reserved and behaves as hold).
  localparam logic [1:0] stackPointerDef  = 2'b00;
  localparam logic [1:0] stackPointerPush = 2'b01;
  localparam logic [1:0] stackPointerPop  = 2'b10;

  // Qualifier FSM: ARMED accepts one op, DONE waits for enMem to drop.
  localparam logic [0:0] ST_ARMED = 1'b0;
  localparam logic [0:0] ST_DONE  = 1'b1;

endpackage

// File: rtl/stack_ram.sv
// Stack storage: DEPTH x WIDTH, synchronous write, asynchronous read, no reset.
// Ports:
//   clk    in  : write clock, rising edge
//   we     in  : write enable
//   waddr  in  : write index
//   wdata  in  : write data
//   raddr  in  : read index
//   rdata  out : combinational read data
module stack_ram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stack_unit.sv
// MEM-stage return/data stack executing PUSH/POP/CALL/RET for the control unit.
// Ports:
//   clock, reset          : rising-edge clock, async active-high reset
//   enMem, sigStackMem    : op qualifiers from the control unit
//   sigNewSP              : 00 hold, 01 push, 10 pop, 11 hold
//   sigAddData            : push source, 1 = pcReturn (CALL), 0 = regData (PUSH)
//   pcReturn, regData     : push data candidates
//   stackData             : last popped word (registered)
//   fullFlag, emptyFlag   : decoded from the stack pointer
//   overflowErr, underflowErr : sticky misuse flags, cleared only by reset
//   stackDepth            : current stack pointer
// Handshake: an op is taken on the first rising edge where enMem=1,
// sigStackMem=1, sigNewSP is push/pop and the qualifier is ARMED; further
// ops wait until an edge sees enMem=0, so a held request executes once.
module stack_unit
  import stack_unit_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enMem,
  input  logic             sigStackMem,
  input  logic [1:0]       sigNewSP,
  input  logic             sigAddData,
  input  logic [WIDTH-1:0] pcReturn,
  input  logic [WIDTH-1:0] regData,
  output logic [WIDTH-1:0] stackData,
  output logic             fullFlag,
  output logic             emptyFlag,
  output logic             overflowErr,
  output logic             underflowErr,
  output logic [PTR_W:0]   stackDepth
);

  localparam logic [PTR_W:0]   SP_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   SP_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] IDX_ONE = PTR_W'(1);

  logic [PTR_W:0]   sp_q, sp_d;
  logic [WIDTH-1:0] stack_data_q, stack_data_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [0:0]       state_q, state_d;

  logic             is_push, is_pop, op_go, full, empty;
  logic             ram_we;
  logic [PTR_W-1:0] ram_waddr, ram_raddr;
  logic [WIDTH-1:0] ram_wdata, ram_rdata;

  assign is_push = (sigNewSP == stackPointerPush);
  assign is_pop  = (sigNewSP == stackPointerPop);
  assign op_go   = enMem && sigStackMem && (is_push || is_pop) && (state_q == ST_ARMED);
  assign full    = (sp_q == SP_FULL);
  assign empty   = (sp_q == '0);

  // Low bits index the RAM; at sp==DEPTH they wrap to 0, so sp-1 still
  // addresses the top entry DEPTH-1.
  assign ram_waddr = sp_q[PTR_W-1:0];
  assign ram_raddr = sp_q[PTR_W-1:0] - IDX_ONE;
  assign ram_wdata = sigAddData ? pcReturn : regData;

  always_comb begin
    sp_d         = sp_q;
    stack_data_d = stack_data_q;
    ovf_d        = ovf_q;
    unf_d        = unf_q;
    state_d      = state_q;
    ram_we       = 1'b0;
    if (op_go) begin
      // Rejected ops also consume the arm.
      state_d = ST_DONE;
      if (is_push) begin
        if (full) begin
          ovf_d = 1'b1;
        end else begin
          ram_we = 1'b1;
          sp_d   = sp_q + SP_ONE;
        end
      end else begin
        if (empty) begin
          unf_d = 1'b1;
        end else begin
          sp_d         = sp_q - SP_ONE;
          stack_data_d = ram_rdata;
        end
      end
    end else if (!enMem) begin
      state_d = ST_ARMED;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sp_q         <= '0;
      stack_data_q <= '0;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
      state_q      <= ST_ARMED;
    end else begin
      sp_q         <= sp_d;
      stack_data_q <= stack_data_d;
      ovf_q        <= ovf_d;
      unf_q        <= unf_d;
      state_q      <= state_d;
    end
  end

  stack_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ram (
    .clk   (clock),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  assign stackData    = stack_data_q;
  assign fullFlag     = full;
  assign emptyFlag    = empty;
  assign overflowErr  = ovf_q;
  assign underflowErr = unf_q;
  assign stackDepth   = sp_q;

endmodule

// File: tb/tb_stack_unit.sv
// Self-checking bench for stack_unit: directed scenarios with literal
// expectations plus randomized traffic, all compared every cycle against a
// queue-based model of the stack.
module tb_stack_unit;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int PTR_W = $clog2(DEPTH);

  logic             clock = 1'b0;
  logic             reset;
  logic             enMem, sigStackMem, sigAddData;
  logic [1:0]       sigNewSP;
  logic [WIDTH-1:0] pcReturn, regData;
  logic [WIDTH-1:0] stackData;
  logic             fullFlag, emptyFlag, overflowErr, underflowErr;
  logic [PTR_W:0]   stackDepth;

  int checks = 0;
  int errors = 0;

  // Behavioural model
  logic [WIDTH-1:0] m_stack[$];
  logic [WIDTH-1:0] m_data;
  logic             m_ovf, m_unf, m_armed;

  stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .enMem        (enMem),
    .sigStackMem  (sigStackMem),
    .sigNewSP     (sigNewSP),
    .sigAddData   (sigAddData),
    .pcReturn     (pcReturn),
    .regData      (regData),
    .stackData    (stackData),
    .fullFlag     (fullFlag),
    .emptyFlag    (emptyFlag),
    .overflowErr  (overflowErr),
    .underflowErr (underflowErr),
    .stackDepth   (stackDepth)
  );

  // Clock / reset
  always #5 clock = ~clock;

  // Scoreboard helpers
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_stack.delete();
    m_data  = '0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    m_armed = 1'b1;
  endtask

  // One rising edge worth of stack behaviour, from the current inputs.
  task automatic m_edge();
    bit go;
    if (reset) begin
      m_reset();
    end else begin
      go = enMem && sigStackMem && (sigNewSP == 2'b01 || sigNewSP == 2'b10) && m_armed;
      if (go) begin
        m_armed = 1'b0;
        if (sigNewSP == 2'b01) begin
          if (m_stack.size() == DEPTH) m_ovf = 1'b1;
          else m_stack.push_back(sigAddData ? pcReturn : regData);
        end else begin
          if (m_stack.size() == 0) m_unf = 1'b1;
          else m_data = m_stack.pop_back();
        end
      end else if (!enMem) begin
        m_armed = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    check("stackDepth",   32'(stackDepth),   32'(m_stack.size()));
    check("emptyFlag",    32'(emptyFlag),    32'(m_stack.size() == 0));
    check("fullFlag",     32'(fullFlag),     32'(m_stack.size() == DEPTH));
    check("stackData",    32'(stackData),    32'(m_data));
    check("overflowErr",  32'(overflowErr),  32'(m_ovf));
    check("underflowErr", 32'(underflowErr), 32'(m_unf));
  endtask

  // Advance one cycle: model follows the edge, outputs compared at negedge.
  task automatic tick();
    @(posedge clock);
    m_edge();
    @(negedge clock);
    compare_all();
  endtask

  // Driver tasks
  task automatic drive(input logic en, input logic stk, input logic [1:0] op,
                       input logic sel, input logic [WIDTH-1:0] pc, input logic [WIDTH-1:0] rd);
    enMem       = en;
    sigStackMem = stk;
    sigNewSP    = op;
    sigAddData  = sel;
    pcReturn    = pc;
    regData     = rd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'b00, 1'b0, '0, '0);
  endtask

  // One enMem pulse carrying an op, followed by an idle cycle to re-arm.
  task automatic do_op(input logic [1:0] op, input logic sel,
                       input logic [WIDTH-1:0] pc, input logic [WIDTH-1:0] rd);
    drive(1'b1, 1'b1, op, sel, pc, rd);
    tick();
    idle();
    tick();
  endtask

  task automatic push(input logic [WIDTH-1:0] v);
    do_op(2'b01, 1'b0, 16'hDEAD, v);
  endtask

  task automatic pop();
    do_op(2'b10, 1'b0, '0, '0);
  endtask

  task automatic sync_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    m_reset();
    @(negedge clock);
    @(negedge clock);
    check("reset_depth", 32'(stackDepth), 32'd0);
    check("reset_empty", 32'(emptyFlag),  32'd1);
    check("reset_full",  32'(fullFlag),   32'd0);
    check("reset_data",  32'(stackData),  32'd0);
    reset = 1'b0;
    tick();

    // PUSH/POP basics
    push(16'h1111);
    push(16'h2222);
    check("t1_depth", 32'(stackDepth), 32'd2);
    check("t1_empty", 32'(emptyFlag),  32'd0);
    pop();
    check("t1_pop1", 32'(stackData), 32'h2222);
    pop();
    check("t1_pop2",  32'(stackData), 32'h1111);
    check("t1_empty2", 32'(emptyFlag), 32'd1);

    // CALL / RET
    do_op(2'b01, 1'b1, 16'h0042, 16'hFFFF);
    do_op(2'b10, 1'b1, 16'h0000, 16'h0000);
    check("t2_ret", 32'(stackData), 32'h0042);

    // Fill, overflow, drain
    for (int i = 1; i <= DEPTH + 1; i++) begin
      push(WIDTH'(i));
      if (i == DEPTH) begin
        check("t3_full",  32'(fullFlag),   32'd1);
        check("t3_depth", 32'(stackDepth), 32'd8);
      end
    end
    check("t3_ovf",    32'(overflowErr), 32'd1);
    check("t3_depth9", 32'(stackDepth),  32'd8);
    for (int i = DEPTH; i >= 1; i--) begin
      pop();
      check("t3_drain", 32'(stackData), 32'(i));
    end

    // Underflow after reset
    sync_reset();
    pop();
    check("t4_unf",   32'(underflowErr), 32'd1);
    check("t4_data",  32'(stackData),    32'd0);
    check("t4_depth", 32'(stackDepth),   32'd0);

    // Held request executes once
    sync_reset();
    drive(1'b1, 1'b1, 2'b01, 1'b0, '0, 16'h0A0A);
    repeat (3) tick();
    check("t5_once", 32'(stackDepth), 32'd1);
    idle();
    tick();
    drive(1'b1, 1'b1, 2'b01, 1'b0, '0, 16'h0B0B);
    tick();
    check("t5_rearm", 32'(stackDepth), 32'd2);
    idle();
    tick();

    // Async reset between edges with depth 5 and both errors set
    sync_reset();
    pop();
    for (int i = 0; i < DEPTH + 1; i++) push(16'h5000 + WIDTH'(i));
    repeat (3) pop();
    check("t6_pre_depth", 32'(stackDepth), 32'd5);
    check("t6_pre_errs",  32'({overflowErr, underflowErr}), 32'b11);
    #1 reset = 1'b1;
    #1;
    m_reset();
    check("t6_depth", 32'(stackDepth),   32'd0);
    check("t6_data",  32'(stackData),    32'd0);
    check("t6_empty", 32'(emptyFlag),    32'd1);
    check("t6_full",  32'(fullFlag),     32'd0);
    check("t6_ovf",   32'(overflowErr),  32'd0);
    check("t6_unf",   32'(underflowErr), 32'd0);
    #1 reset = 1'b0;
    tick();
    push(16'hAA55);
    check("t6_depth1", 32'(stackDepth), 32'd1);
    pop();
    check("t6_entry0", 32'(stackData), 32'hAA55);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      drive(($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 8),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            WIDTH'($urandom), WIDTH'($urandom));
      tick();
    end
    reset = 1'b0;
    idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
